// File: rtl/jtag_master_pkg.sv
// Shared op codes, FSM states and fixed TMS sequences for the JTAG initiator.
// Sequences are stored LSB-first: bit i is the TMS value for the i-th TCK of that phase.
package jtag_master_pkg;

  localparam logic [1:0] OP_DR   = 2'd0;
  localparam logic [1:0] OP_IR   = 2'd1;
  localparam logic [1:0] OP_RST  = 2'd2;
  localparam logic [1:0] OP_IDLE = 2'd3;

  typedef enum logic [2:0] {
    S_RSTSEQ,
    S_IDLE,
    S_HDR,
    S_SHIFT,
    S_TRL,
    S_IDLECLK
  } state_e;

  localparam int         RST_LEN    = 6;
  localparam logic [7:0] RST_TMS    = 8'b0001_1111;
  localparam int         DR_HDR_LEN = 3;
  localparam logic [7:0] DR_HDR_TMS = 8'b0000_0001;
  localparam int         IR_HDR_LEN = 4;
  localparam logic [7:0] IR_HDR_TMS = 8'b0000_0011;
  localparam int         TRL_LEN    = 2;
  localparam logic [7:0] TRL_TMS    = 8'b0000_0001;

  // TMS for the fixed-pattern phases; data-dependent phases resolve to 0 here.
  function automatic logic seq_tms(state_e st, logic ir, logic [2:0] idx);
    logic b;
    case (st)
      S_RSTSEQ: b = RST_TMS[idx];
      S_HDR:    b = ir ? IR_HDR_TMS[idx] : DR_HDR_TMS[idx];
      S_TRL:    b = TRL_TMS[idx];
      default:  b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/jtag_master_tckgen.sv
// TCK generator: divides clk by 2*CLKDIV while run is high, idles low.
// rise/fall are combinational strobes for the clk edge on which tck toggles.
module jtag_master_tckgen #(
  parameter int CLKDIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tck,
  output logic rise,
  output logic fall
);

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  logic [DW-1:0] div;
  logic          wrap;

  assign wrap = run && (div == DW'(CLKDIV - 1));
  assign rise = wrap && !tck;
  assign fall = wrap && tck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      tck <= 1'b0;
    end else if (!run) begin
      div <= '0;
    end else if (wrap) begin
      div <= '0;
      tck <= ~tck;
    end else begin
      div <= div + DW'(1);
    end
  end

endmodule

// File: rtl/jtag_master.sv
// JTAG initiator: turns DR/IR scan, TAP reset and idle-clock commands into
// TCK/TMS/TDI activity and returns TDO bits captured during Shift-xR.
module jtag_master
  import jtag_master_pkg::*;
#(
  parameter int W_DATA = 32,
  parameter int CLKDIV = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [$clog2(W_DATA)-1:0] cmd_len,
  input  logic [W_DATA-1:0]         cmd_wdata,
  output logic                      rsp_valid,
  output logic [W_DATA-1:0]         rsp_rdata,
  output logic                      tck,
  output logic                      trst_n,
  output logic                      tms,
  output logic                      tdi,
  input  logic                      tdo
);

  localparam int LW   = $clog2(W_DATA);
  localparam int CNTW = (LW > 3) ? LW : 3;

  state_e            state, nxt_state;
  logic [CNTW-1:0]   cnt, nxt_cnt, len_w;
  logic [LW-1:0]     len;
  logic [W_DATA-1:0] wdata, cap;
  logic              is_ir, is_scan, in_cmd;
  logic              last_bit, nxt_tms, nxt_tdi;
  logic              run, rise, fall;

  assign run   = (state != S_IDLE);
  assign len_w = CNTW'(len);

  jtag_master_tckgen #(.CLKDIV(CLKDIV)) u_tckgen (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .tck  (tck),
    .rise (rise),
    .fall (fall)
  );

  // Next bit position and the TMS/TDI to present after the coming falling edge.
  always_comb begin
    last_bit  = 1'b0;
    nxt_state = state;
    case (state)
      S_RSTSEQ:  last_bit = (cnt == CNTW'(RST_LEN - 1));
      S_HDR:     last_bit = (cnt == (is_ir ? CNTW'(IR_HDR_LEN - 1) : CNTW'(DR_HDR_LEN - 1)));
      S_SHIFT,
      S_IDLECLK: last_bit = (cnt == len_w);
      S_TRL:     last_bit = (cnt == CNTW'(TRL_LEN - 1));
      default:   last_bit = 1'b0;
    endcase
    if (last_bit) begin
      case (state)
        S_HDR:   nxt_state = S_SHIFT;
        S_SHIFT: nxt_state = S_TRL;
        default: nxt_state = S_IDLE;
      endcase
    end
    nxt_cnt = last_bit ? '0 : cnt + CNTW'(1);
    if (nxt_state == S_SHIFT) begin
      nxt_tms = (nxt_cnt == len_w);
      nxt_tdi = wdata[nxt_cnt[LW-1:0]];
    end else begin
      nxt_tms = seq_tms(nxt_state, is_ir, nxt_cnt[2:0]);
      nxt_tdi = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RSTSEQ;
      cnt       <= '0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      len       <= '0;
      wdata     <= '0;
      cap       <= '0;
      is_ir     <= 1'b0;
      is_scan   <= 1'b0;
      in_cmd    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            len       <= cmd_len;
            wdata     <= cmd_wdata;
            cap       <= '0;
            is_ir     <= (cmd_op == OP_IR);
            is_scan   <= (cmd_op == OP_DR) || (cmd_op == OP_IR);
            in_cmd    <= 1'b1;
            cnt       <= '0;
            tdi       <= 1'b0;
            case (cmd_op)
              OP_DR, OP_IR: begin
                state <= S_HDR;
                tms   <= seq_tms(S_HDR, cmd_op == OP_IR, 3'd0);
              end
              OP_RST: begin
                state <= S_RSTSEQ;
                tms   <= seq_tms(S_RSTSEQ, 1'b0, 3'd0);
              end
              default: begin
                state <= S_IDLECLK;
                tms   <= 1'b0;
              end
            endcase
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          if (rise && state == S_SHIFT)
            cap[cnt[LW-1:0]] <= tdo;
          if (fall) begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            tms   <= nxt_tms;
            tdi   <= nxt_tdi;
            // The power-on reset sequence has no requester, so it never responds.
            if (nxt_state == S_IDLE && in_cmd) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= is_scan ? cap : '0;
              in_cmd    <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trst_n <= 1'b0;
    else        trst_n <= 1'b1;
  end

endmodule
